// File: rtl/rng_engine.sv
// Random word generator: a Fibonacci LFSR and a companion NLFSR, seeded together,
// warmed up for WARMUP steps, then mapped to OUT_W-bit words behind a valid/ready handshake.
module rng_engine #(
    parameter int WIDTH  = 16,
    parameter int OUT_W  = 8,
    parameter int WARMUP = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] seed,
    input  logic             seed_load,
    output logic [OUT_W-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             running
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WARMUP,
        ST_RUN
    } state_t;

    // Tap positions for each supported width, packed into one 32-bit constant.
    localparam logic [31:0] TAP32 = (WIDTH == 8)  ? 32'h0000_00B8 :
                                    (WIDTH == 16) ? 32'h0000_D008 :
                                                    32'h8020_0003;
    localparam logic [WIDTH-1:0] TAP_MASK   = TAP32[WIDTH-1:0];
    localparam logic [WIDTH-1:0] GEN_ONE    = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [OUT_W-1:0] OUT_ONE    = {{(OUT_W-1){1'b0}}, 1'b1};
    localparam int               IDX_W      = $clog2(OUT_W);
    localparam logic [7:0]       WARMUP_CNT = 8'(WARMUP);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] l_q, l_d;
    logic [WIDTH-1:0] n_q, n_d;
    logic [7:0]       cnt_q, cnt_d;
    logic [OUT_W-1:0] out_data_q, out_data_d;
    logic             out_valid_q, out_valid_d;

    function automatic logic [WIDTH-1:0] lfsr_next(input logic [WIDTH-1:0] v);
        return {v[WIDTH-2:0], ^(v & TAP_MASK)};
    endfunction

    // The AND term makes the NLFSR able to collapse to zero; force it back to 1.
    function automatic logic [WIDTH-1:0] nlfsr_next(input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] nxt;
        nxt = {v[WIDTH-2:0], (^(v & TAP_MASK)) ^ (v[1] & v[2])};
        return (nxt == '0) ? GEN_ONE : nxt;
    endfunction

    function automatic logic [OUT_W-1:0] map_word(input logic [1:0]       m,
                                                  input logic [WIDTH-1:0] l,
                                                  input logic [WIDTH-1:0] n);
        logic [OUT_W-1:0] w;
        case (m)
            2'b00:   w = l[OUT_W-1:0];
            2'b01:   w = n[OUT_W-1:0];
            2'b10:   w = OUT_ONE << l[IDX_W-1:0];
            default: w = l[OUT_W-1:0] ^ n[OUT_W-1:0];
        endcase
        return w;
    endfunction

    always_comb begin
        state_d     = state_q;
        l_d         = l_q;
        n_d         = n_q;
        cnt_d       = cnt_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        if (seed_load) begin
            // Reseeding wins over any handshake; a pending word is dropped.
            l_d         = (seed == '0) ? GEN_ONE : seed;
            n_d         = (~seed == '0) ? GEN_ONE : ~seed;
            cnt_d       = '0;
            out_valid_d = 1'b0;
            state_d     = ST_WARMUP;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    out_valid_d = 1'b0;
                end
                ST_WARMUP: begin
                    if (cnt_q == WARMUP_CNT) begin
                        state_d = ST_RUN;
                    end else begin
                        l_d   = lfsr_next(l_q);
                        n_d   = nlfsr_next(n_q);
                        cnt_d = cnt_q + 8'd1;
                    end
                end
                ST_RUN: begin
                    if (!out_valid_q || out_ready) begin
                        out_data_d  = map_word(mode, l_q, n_q);
                        out_valid_d = 1'b1;
                        l_d         = lfsr_next(l_q);
                        n_d         = nlfsr_next(n_q);
                    end
                end
                default: begin
                    state_d     = ST_IDLE;
                    out_valid_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            l_q         <= GEN_ONE;
            n_q         <= GEN_ONE;
            cnt_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            l_q         <= l_d;
            n_q         <= n_d;
            cnt_q       <= cnt_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign running   = (state_q == ST_RUN);

endmodule

// File: tb/tb_rng_engine.sv
// Directed bench for rng_engine at WIDTH=8, OUT_W=8, WARMUP=4 with hand-derived
// LFSR/NLFSR sequences and a small 8-bit LFSR reference for the long runs.
module tb_rng_engine;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] mode;
    logic [7:0] seed;
    logic       seed_load;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       running;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    rng_engine #(
        .WIDTH (8),
        .OUT_W (8),
        .WARMUP(4)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .mode     (mode),
        .seed     (seed),
        .seed_load(seed_load),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .running  (running)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] ref_lfsr(input logic [7:0] v);
        logic fb;
        fb = v[7] ^ v[5] ^ v[4] ^ v[3];
        return {v[6:0], fb};
    endfunction

    task automatic load_seed(input logic [7:0] s);
        seed      = s;
        seed_load = 1'b1;
        tick();
        seed_load = 1'b0;
    endtask

    task automatic wait_running(input string tag);
        int k;
        k = 0;
        while (!running && k < 20) begin
            tick();
            k++;
        end
        check_eq(tag, 32'(k), 32'd5);
    endtask

    task automatic expect_word(input string tag, input logic [7:0] exp);
        tick();
        check_eq(tag, 32'({out_valid, out_data}), 32'({1'b1, exp}));
    endtask

    initial begin
        logic [7:0] ml;
        logic [7:0] one_h;
        int zeros;
        int bad;
        int bad_hot;

        reset     = 1'b0;
        seed_load = 1'b0;
        seed      = 8'h00;
        mode      = 2'b00;
        out_ready = 1'b0;
        tick();
        tick();
        check_eq("rst_outs", 32'({out_data, out_valid, running}), 32'd0);

        reset     = 1'b1;
        out_ready = 1'b1;
        repeat (3) tick();
        check_eq("idle_hold", 32'({out_valid, running}), 32'd0);

        // Seed 0x01, mode 00: L after warmup is 0x11, then 0x23, 0x47.
        load_seed(8'h01);
        check_eq("load_not_run", 32'(running), 32'd0);
        wait_running("warm_lat");
        expect_word("w0_11", 8'h11);
        expect_word("w1_23", 8'h23);
        expect_word("w2_47", 8'h47);

        // Same seed, mode change per word. N after warmup: E9, D3, A6, 4D, 9B.
        load_seed(8'h01);
        wait_running("warm_lat2");
        mode = 2'b01;
        expect_word("m01_n", 8'hE9);
        mode = 2'b11;
        expect_word("m11_xor", 8'hF0);
        mode = 2'b10;
        expect_word("m10_hot", 8'h80);
        mode = 2'b00;
        expect_word("m00_l", 8'h8E);

        // Backpressure: word held, mode change ignored while held.
        out_ready = 1'b0;
        mode      = 2'b01;
        for (int i = 0; i < 10; i++) begin
            tick();
            check_eq("stall_hold", 32'({out_valid, out_data}), 32'h18E);
        end
        out_ready = 1'b1;
        expect_word("resume_n", 8'h9B);
        mode = 2'b00;
        expect_word("resume_l", 8'h38);

        // Reseed with zero while a word is being accepted.
        load_seed(8'h00);
        check_eq("reload_clr", 32'({out_valid, running}), 32'd0);
        wait_running("warm_lat3");
        expect_word("z_l", 8'h11);
        mode = 2'b01;
        expect_word("z_n_ff", 8'hFF);
        mode = 2'b11;
        expect_word("z_xor", 8'hB8);

        mode  = 2'b00;
        ml    = 8'h8E;
        zeros = 0;
        bad   = 0;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (out_data == 8'h00) zeros++;
            if (!out_valid || out_data != ml) bad++;
            ml = ref_lfsr(ml);
        end
        check_eq("run300_zero", 32'(zeros), 32'd0);
        check_eq("run300_seq", 32'(bad), 32'd0);

        mode    = 2'b10;
        bad     = 0;
        bad_hot = 0;
        for (int i = 0; i < 64; i++) begin
            tick();
            one_h = 8'd1 << ml[2:0];
            if ($countones(out_data) != 1) bad_hot++;
            if (!out_valid || out_data != one_h) bad++;
            ml = ref_lfsr(ml);
        end
        check_eq("hot_single", 32'(bad_hot), 32'd0);
        check_eq("hot_index", 32'(bad), 32'd0);

        // Reset in the middle of warmup.
        mode = 2'b00;
        load_seed(8'h05);
        tick();
        tick();
        reset = 1'b0;
        tick();
        check_eq("rst_warm", 32'({out_data, out_valid, running}), 32'd0);
        reset = 1'b1;
        repeat (10) tick();
        check_eq("idle_after_warm", 32'({out_data, out_valid, running}), 32'd0);

        // Reset in RUN, colliding with a seed load.
        load_seed(8'h01);
        wait_running("warm_lat4");
        expect_word("pre_rst", 8'h11);
        reset     = 1'b0;
        seed      = 8'h22;
        seed_load = 1'b1;
        tick();
        seed_load = 1'b0;
        check_eq("rst_run", 32'({out_data, out_valid, running}), 32'd0);
        reset = 1'b1;
        repeat (10) tick();
        check_eq("idle_after_run", 32'({out_data, out_valid, running}), 32'd0);

        load_seed(8'h01);
        wait_running("warm_lat5");
        expect_word("post_rst_11", 8'h11);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
